// File: rtl/div_ctrl_hilo_if.sv
// Request, HI/LO result and divider handshake bundle
// shared by div_ctrl_hilo and its environment.
interface div_ctrl_hilo_if;
    logic        DivOp;
    logic        DivSigned;
    logic [31:0] A;
    logic [31:0] B;
    logic        iniciar;
    logic        sinal;
    logic [31:0] Dvdendo;
    logic [31:0] Divsor;
    logic [31:0] quociente;
    logic [31:0] resto;
    logic        dividindo;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Busy;
    logic        Done;
    logic        DivZero;
    logic        DivErr;

    modport master (
        input  DivOp, DivSigned, A, B,
        input  quociente, resto, dividindo,
        output iniciar, sinal, Dvdendo, Divsor,
        output Hi, Lo, Busy, Done, DivZero, DivErr
    );

    modport slave (
        output DivOp, DivSigned, A, B,
        output quociente, resto, dividindo,
        input  iniciar, sinal, Dvdendo, Divsor,
        input  Hi, Lo, Busy, Done, DivZero, DivErr
    );
endinterface

// File: rtl/div_ctrl_hilo.sv
// DIV/DIVU control in front of the unsigned restoring divider:
// magnitude conversion, start/busy handshake, sign fix-up into HI/LO.
module div_ctrl_hilo #(
    parameter int MINWAIT = 2,
    parameter int MAXWAIT = 48
) (
    input logic             Clk,
    input logic             Reset,
    div_ctrl_hilo_if.master bus
);
    localparam int CW = $clog2(MAXWAIT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ZERO,
        LOAD,
        RUN,
        DONE,
        ERR
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] wait_cnt;
    logic          neg_quo;
    logic          neg_rem;
    logic [31:0]   dvd_q;
    logic [31:0]   dvs_q;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic [31:0]   dvd_mag;
    logic [31:0]   dvs_mag;
    logic          accept;
    logic          finish;
    logic          timeout;

    always_comb begin
        dvd_mag = bus.A;
        dvs_mag = bus.B;
        if (bus.DivSigned && bus.A[31])
            dvd_mag = ~bus.A + 32'd1;
        if (bus.DivSigned && bus.B[31])
            dvs_mag = ~bus.B + 32'd1;
        accept  = bus.DivOp && (bus.B != 32'd0);
        // early dividindo=0 is stale from the previous run
        finish  = (int'(wait_cnt) >= MINWAIT) && !bus.dividindo;
        timeout = (int'(wait_cnt) == MAXWAIT - 1);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.DivOp)
                    state_nxt = accept ? LOAD : ZERO;
            end
            ZERO: state_nxt = IDLE;
            LOAD: state_nxt = RUN;
            RUN: begin
                if (finish)
                    state_nxt = DONE;
                else if (timeout)
                    state_nxt = ERR;
            end
            DONE: state_nxt = IDLE;
            ERR:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            dvd_q    <= 32'd0;
            dvs_q    <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept) begin
                neg_quo <= bus.DivSigned & (bus.A[31] ^ bus.B[31]);
                neg_rem <= bus.DivSigned & bus.A[31];
                dvd_q   <= dvd_mag;
                dvs_q   <= dvs_mag;
            end
            if (state == LOAD)
                wait_cnt <= '0;
            else if (state == RUN)
                wait_cnt <= wait_cnt + CW'(1);
            if (state == RUN && finish) begin
                lo_q <= neg_quo ? ~bus.quociente + 32'd1
                                : bus.quociente;
                hi_q <= neg_rem ? ~bus.resto + 32'd1
                                : bus.resto;
            end
        end
    end

    assign bus.iniciar = (state == RUN);
    assign bus.sinal   = 1'b0;
    assign bus.Dvdendo = dvd_q;
    assign bus.Divsor  = dvs_q;
    assign bus.Hi      = hi_q;
    assign bus.Lo      = lo_q;
    assign bus.Busy    = (state == LOAD) || (state == RUN)
                      || (state == DONE);
    assign bus.Done    = (state == DONE);
    assign bus.DivZero = (state == ZERO);
    assign bus.DivErr  = (state == ERR);
endmodule

// File: tb/tb_div_ctrl_hilo.sv
// Bench for div_ctrl_hilo: stub divider with 34-cycle busy window,
// longint reference model for DIV/DIVU results.
module tb_div_ctrl_hilo;
    logic Clk = 1'b0;
    logic Reset;
    int   errors = 0;
    int   checks = 0;
    int   dcnt = 0;
    bit   stuck = 1'b0;

    always #5 Clk = ~Clk;

    div_ctrl_hilo_if bus ();

    div_ctrl_hilo #(
        .MINWAIT(2),
        .MAXWAIT(48)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    // stub divider: cleared while iniciar low, done 34 edges after start
    always @(posedge Clk) begin
        if (!bus.iniciar)
            dcnt <= 0;
        else if (dcnt < 34)
            dcnt <= dcnt + 1;
    end

    assign bus.dividindo = stuck || (dcnt < 34);
    assign bus.quociente = (bus.Divsor == 32'd0) ? 32'hFFFF_FFFF
                         : bus.Dvdendo / bus.Divsor;
    assign bus.resto     = (bus.Divsor == 32'd0) ? bus.Dvdendo
                         : bus.Dvdendo % bus.Divsor;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void ref_div(
        input bit s, input logic [31:0] a, input logic [31:0] b,
        output logic [31:0] q, output logic [31:0] r,
        output logic [31:0] ma, output logic [31:0] mb);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q  = 32'(sa / sb);
        r  = 32'(sa % sb);
        ma = 32'((sa < 0) ? -sa : sa);
        mb = 32'((sb < 0) ? -sb : sb);
    endfunction

    task automatic start(input bit s, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge Clk);
        bus.DivOp     = 1'b1;
        bus.DivSigned = s;
        bus.A         = a;
        bus.B         = b;
        @(posedge Clk);
        #1;
    endtask

    task automatic run_op(input string tag, input bit s,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r, ma, mb;
        int n;
        int first_ini;
        ref_div(s, a, b, q, r, ma, mb);
        start(s, a, b);
        bus.DivOp     = 1'b0;
        bus.DivSigned = ~s;
        bus.A         = $urandom;
        bus.B         = $urandom;
        chk({tag, ":busy"}, 32'(bus.Busy), 32'd1);
        n = 0;
        first_ini = -1;
        while (!bus.Done && n < 100) begin
            @(posedge Clk);
            #1;
            n++;
            if (bus.iniciar && first_ini < 0)
                first_ini = n;
        end
        chk({tag, ":lat"}, 32'(n), 32'd36);
        chk({tag, ":ini"}, 32'(first_ini), 32'd1);
        chk({tag, ":dvd"}, bus.Dvdendo, ma);
        chk({tag, ":dvs"}, bus.Divsor, mb);
        chk({tag, ":lo"}, bus.Lo, q);
        chk({tag, ":hi"}, bus.Hi, r);
        @(posedge Clk);
        #1;
        chk({tag, ":done1"}, 32'(bus.Done), 32'd0);
        chk({tag, ":idle"}, 32'(bus.Busy), 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] ra, rb;
        bit rs;
        Reset         = 1'b0;
        bus.DivOp     = 1'b0;
        bus.DivSigned = 1'b0;
        bus.A         = 32'd0;
        bus.B         = 32'd0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst:hi", bus.Hi, 32'd0);
        chk("rst:lo", bus.Lo, 32'd0);
        chk("rst:busy", 32'(bus.Busy), 32'd0);
        chk("rst:ini", 32'(bus.iniciar), 32'd0);
        chk("rst:dvd", bus.Dvdendo, 32'd0);
        chk("rst:flags", {29'd0, bus.Done, bus.DivZero, bus.DivErr},
            32'd0);
        @(negedge Clk);
        Reset = 1'b1;

        run_op("divu100_7", 1'b0, 32'd100, 32'd7);
        chk("divu:lo14", bus.Lo, 32'd14);
        chk("divu:hi2", bus.Hi, 32'd2);
        chk("sinal", 32'(bus.sinal), 32'd0);
        run_op("div-100_7", 1'b1, 32'hFFFF_FF9C, 32'd7);
        chk("sdiv1:lo", bus.Lo, 32'hFFFF_FFF2);
        chk("sdiv1:hi", bus.Hi, 32'hFFFF_FFFE);
        run_op("div100_-7", 1'b1, 32'd100, 32'hFFFF_FFF9);
        chk("sdiv2:lo", bus.Lo, 32'hFFFF_FFF2);
        chk("sdiv2:hi", bus.Hi, 32'd2);
        run_op("ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("ovf:lo", bus.Lo, 32'h8000_0000);
        chk("ovf:hi", bus.Hi, 32'd0);
        run_op("divu_max", 1'b0, 32'hFFFF_FFFF, 32'd1);
        run_op("div_min_2", 1'b1, 32'h8000_0000, 32'd2);

        // divide by zero keeps the previous HI/LO
        run_op("pre_zero", 1'b0, 32'd100, 32'd7);
        start(1'b0, 32'd55, 32'd0);
        bus.DivOp = 1'b0;
        chk("zero:pulse", 32'(bus.DivZero), 32'd1);
        chk("zero:ini", 32'(bus.iniciar), 32'd0);
        chk("zero:busy", 32'(bus.Busy), 32'd0);
        @(posedge Clk);
        #1;
        chk("zero:pulse_end", 32'(bus.DivZero), 32'd0);
        chk("zero:ini2", 32'(bus.iniciar), 32'd0);
        chk("zero:hi", bus.Hi, 32'd2);
        chk("zero:lo", bus.Lo, 32'd14);

        // DivOp held high across two operations
        start(1'b0, 32'd100, 32'd7);
        bus.A = 32'd9;
        bus.B = 32'd3;
        n = 0;
        while (!bus.Done && n < 100) begin
            @(posedge Clk);
            #1;
            n++;
        end
        chk("hold1:lat", 32'(n), 32'd36);
        chk("hold1:lo", bus.Lo, 32'd14);
        chk("hold1:hi", bus.Hi, 32'd2);
        @(posedge Clk);
        #1;
        chk("hold:idle", 32'(bus.Busy), 32'd0);
        @(posedge Clk);
        #1;
        chk("hold:reaccept", 32'(bus.Busy), 32'd1);
        bus.DivOp = 1'b0;
        n = 0;
        while (!bus.Done && n < 100) begin
            @(posedge Clk);
            #1;
            n++;
            if (n == 10) begin
                bus.DivOp = 1'b1;
                bus.A     = 32'd5;
                bus.B     = 32'd0;
            end
            if (n == 11)
                bus.DivOp = 1'b0;
            if (bus.DivZero)
                chk("run:ignore_op", 32'(bus.DivZero), 32'd0);
        end
        chk("hold2:lat", 32'(n), 32'd36);
        chk("hold2:lo", bus.Lo, 32'd3);
        chk("hold2:hi", bus.Hi, 32'd0);
        repeat (2) @(posedge Clk);
        #1;
        chk("hold2:stay_idle", 32'(bus.Busy), 32'd0);

        // asynchronous reset in the middle of a run
        run_op("pre_rst", 1'b0, 32'd100, 32'd7);
        start(1'b0, 32'd1000, 32'd3);
        bus.DivOp = 1'b0;
        repeat (20) @(posedge Clk);
        #1;
        chk("mid:ini_high", 32'(bus.iniciar), 32'd1);
        Reset = 1'b0;
        #1;
        chk("mid:ini", 32'(bus.iniciar), 32'd0);
        chk("mid:busy", 32'(bus.Busy), 32'd0);
        chk("mid:hi", bus.Hi, 32'd0);
        chk("mid:lo", bus.Lo, 32'd0);
        @(negedge Clk);
        Reset = 1'b1;

        // divider never finishes
        run_op("pre_tmo", 1'b0, 32'd100, 32'd7);
        stuck = 1'b1;
        start(1'b0, 32'd200, 32'd9);
        bus.DivOp = 1'b0;
        n = 0;
        while (!bus.DivErr && n < 100) begin
            @(posedge Clk);
            #1;
            n++;
        end
        chk("tmo:edge", 32'(n), 32'd49);
        chk("tmo:hi", bus.Hi, 32'd2);
        chk("tmo:lo", bus.Lo, 32'd14);
        chk("tmo:ini", 32'(bus.iniciar), 32'd0);
        chk("tmo:done", 32'(bus.Done), 32'd0);
        @(posedge Clk);
        #1;
        chk("tmo:pulse_end", 32'(bus.DivErr), 32'd0);
        stuck = 1'b0;

        for (int i = 0; i < 12; i++) begin
            rs = 1'($urandom);
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0)
                rb = 32'($urandom_range(1, 15));
            if ($urandom_range(0, 3) == 0)
                rb = ~rb;
            if (rb == 32'd0)
                rb = 32'd1;
            run_op($sformatf("rnd%0d", i), rs, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
